// File: rtl/sonar_sequencer.sv
// rtl/sonar_sequencer.sv - round-robin sonar trigger/echo timing sequencer

module sonar_ripple_add14 (
    input  logic [13:0] a,
    input  logic [13:0] b,
    input  logic        c_in,
    output logic [13:0] sum,
    output logic        c_out
);
    logic carry;

    always_comb begin
        carry = c_in;
        sum   = '0;
        for (int i = 0; i < 14; i++) begin
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        c_out = carry;
    end
endmodule

module sonar_sequencer #(
    parameter int N_SONARS     = 4,
    parameter int TICK_DIV     = 50,
    parameter int TRIG_TICKS   = 10,
    parameter int RISE_TIMEOUT = 1000,
    parameter int GAP_TICKS    = 10000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [N_SONARS-1:0] echo,
    output logic [N_SONARS-1:0] trig,
    output logic [13:0]         dist_data,
    output logic [2:0]          dist_id,
    output logic                dist_valid,
    output logic                dist_timeout,
    output logic                busy
);
    localparam int PW = $clog2(TICK_DIV);

    typedef enum logic [2:0] {
        S_IDLE,
        S_TRIG,
        S_WAIT_RISE,
        S_MEASURE,
        S_GAP
    } state_t;

    state_t              state, state_d;
    logic [N_SONARS-1:0] echo_m, echo_s, echo_q;
    logic [N_SONARS-1:0] trig_d;
    logic [2:0]          idx, idx_d;
    logic [PW-1:0]       presc;
    logic                tick;
    logic [15:0]         tick_cnt;
    logic [13:0]         width, width_sum;
    logic                width_co, ovf, ovf_set;
    logic                sel_now, sel_prev, rise, fall;
    logic                pub, pub_timeout, width_clr;
    logic [13:0]         pub_data;

    sonar_ripple_add14 u_width_add (
        .a     (width),
        .b     (14'd1),
        .c_in  (1'b0),
        .sum   (width_sum),
        .c_out (width_co)
    );

    assign tick    = (presc == PW'(TICK_DIV - 1));
    assign busy    = (state != S_IDLE);
    assign ovf_set = (state == S_MEASURE) && tick && width_co && !ovf;
    assign rise    = sel_now && !sel_prev;
    assign fall    = !sel_now && sel_prev;

    // Only the selected sonar's synchronised echo is examined
    always_comb begin
        sel_now  = 1'b0;
        sel_prev = 1'b0;
        for (int i = 0; i < N_SONARS; i++) begin
            if (idx == 3'(i)) begin
                sel_now  = echo_s[i];
                sel_prev = echo_q[i];
            end
        end
    end

    always_comb begin
        state_d     = state;
        idx_d       = idx;
        pub         = 1'b0;
        pub_timeout = 1'b0;
        pub_data    = width;
        width_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                if (enable) state_d = S_TRIG;
            end
            S_TRIG: begin
                if (tick && tick_cnt == 16'(TRIG_TICKS - 1)) state_d = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (rise) begin
                    state_d   = S_MEASURE;
                    width_clr = 1'b1;
                end else if (tick && tick_cnt == 16'(RISE_TIMEOUT - 1)) begin
                    pub         = 1'b1;
                    pub_timeout = 1'b1;
                    pub_data    = 14'h3FFF;
                    state_d     = S_GAP;
                end
            end
            S_MEASURE: begin
                if (fall) begin
                    pub         = 1'b1;
                    pub_timeout = ovf;
                    pub_data    = ovf ? 14'h3FFF : width;
                    state_d     = S_GAP;
                end else if (ovf && tick && tick_cnt == 16'(RISE_TIMEOUT - 1)) begin
                    pub         = 1'b1;
                    pub_timeout = 1'b1;
                    pub_data    = 14'h3FFF;
                    state_d     = S_GAP;
                end
            end
            S_GAP: begin
                if (tick && tick_cnt == 16'(GAP_TICKS - 1)) begin
                    idx_d   = (idx == 3'(N_SONARS - 1)) ? 3'd0 : idx + 3'd1;
                    state_d = enable ? S_TRIG : S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Trigger follows the next state so it is high for exactly the TRIG dwell
    always_comb begin
        trig_d = '0;
        for (int i = 0; i < N_SONARS; i++) begin
            trig_d[i] = (state_d == S_TRIG) && (idx_d == 3'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_IDLE;
            idx          <= 3'd0;
            echo_m       <= '0;
            echo_s       <= '0;
            echo_q       <= '0;
            trig         <= '0;
            presc        <= '0;
            tick_cnt     <= 16'd0;
            width        <= 14'd0;
            ovf          <= 1'b0;
            dist_data    <= 14'd0;
            dist_id      <= 3'd0;
            dist_valid   <= 1'b0;
            dist_timeout <= 1'b0;
        end else begin
            echo_m <= echo;
            echo_s <= echo_m;
            echo_q <= echo_s;
            state  <= state_d;
            idx    <= idx_d;
            trig   <= trig_d;

            if (state_d != state || tick) presc <= '0;
            else                          presc <= presc + PW'(1);

            // Restarting the tick count at overflow times the post-saturation wait
            if (state_d != state || ovf_set) tick_cnt <= 16'd0;
            else if (tick)                   tick_cnt <= tick_cnt + 16'd1;

            if (width_clr) begin
                width <= 14'd0;
                ovf   <= 1'b0;
            end else if (state == S_MEASURE && tick) begin
                if (width_co) ovf   <= 1'b1;
                else          width <= width_sum;
            end

            dist_valid <= pub;
            if (pub) begin
                dist_data    <= pub_data;
                dist_id      <= idx;
                dist_timeout <= pub_timeout;
            end
        end
    end
endmodule

// File: tb/tb_sonar_sequencer.sv
// tb/tb_sonar_sequencer.sv - scoreboard bench for sonar_sequencer

module tb_sonar_sequencer;
    localparam int N   = 4;
    localparam int TD  = 2;
    localparam int MAXW = 3000;

    logic         clk, reset, enable;
    logic [N-1:0] echo;
    logic [N-1:0] trig;
    logic [13:0]  dist_data;
    logic [2:0]   dist_id;
    logic         dist_valid, dist_timeout, busy;

    typedef struct {
        logic [2:0]  id;
        logic [13:0] data;
        logic        tmo;
        int          tol;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    sonar_sequencer #(
        .N_SONARS     (N),
        .TICK_DIV     (TD),
        .TRIG_TICKS   (3),
        .RISE_TIMEOUT (20),
        .GAP_TICKS    (5)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .echo         (echo),
        .trig         (trig),
        .dist_data    (dist_data),
        .dist_id      (dist_id),
        .dist_valid   (dist_valid),
        .dist_timeout (dist_timeout),
        .busy         (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, req);
        end
    endtask

    task automatic expect_pub(input logic [2:0] id, input logic [13:0] data, input logic tmo, input int tol);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.tmo  = tmo;
        e.tol  = tol;
        sb.push_back(e);
    endtask

    task automatic wait_trig(output logic [N-1:0] seen);
        int n;
        n = 0;
        while (trig != '0 && n < MAXW) begin @(negedge clk); n++; end
        while (trig == '0 && n < MAXW) begin @(negedge clk); n++; end
        seen = trig;
        if (n >= MAXW) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_trig: no trigger within %0d cycles", MAXW);
        end
    endtask

    task automatic wait_trig_fall();
        int n;
        n = 0;
        while (trig != '0 && n < MAXW) begin @(negedge clk); n++; end
        if (n >= MAXW) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_trig_fall: trigger stuck, got %0h", trig);
        end
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while (busy && n < maxc) begin @(negedge clk); n++; end
        if (n >= maxc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_idle: busy still %0b after %0d cycles", busy, maxc);
        end
    endtask

    task automatic fire_echo(input int k, input int delay, input int ticks);
        wait_trig_fall();
        repeat (delay) @(negedge clk);
        echo[k] = 1'b1;
        repeat (ticks * TD) @(negedge clk);
        echo[k] = 1'b0;
    endtask

    // Monitor: pops an expectation on every publish, checks trig stays one-hot-or-zero
    initial begin
        exp_t         e;
        logic [N-1:0] prev_trig;
        int           diff;
        prev_trig = '0;
        forever begin
            @(negedge clk);
            if (trig != prev_trig) begin
                n_cmp++;
                if (!$onehot0(trig)) begin
                    n_bad++;
                    $display("FAIL trig_onehot: got %0h, expected one-hot or zero", trig);
                end
                prev_trig = trig;
            end
            if (dist_valid) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_publish: got id %0d data %0h, expected none", dist_id, dist_data);
                end else begin
                    e = sb.pop_front();
                    check("pub_id", 32'(dist_id), 32'(e.id));
                    check("pub_timeout", 32'(dist_timeout), 32'(e.tmo));
                    diff = int'(dist_data) - int'(e.data);
                    n_cmp++;
                    if (diff < -e.tol || diff > e.tol) begin
                        n_bad++;
                        $display("FAIL pub_data: got %0h, expected %0h +/- %0d", dist_data, e.data, e.tol);
                    end
                end
            end
        end
    end

    initial begin
        logic [N-1:0] seen;
        int           w;
        reset  = 1'b1;
        enable = 1'b0;
        echo   = '0;
        repeat (3) @(negedge clk);
        check("rst_trig", 32'(trig), 32'h0);
        check("rst_dist_data", 32'(dist_data), 32'h0);
        check("rst_dist_id", 32'(dist_id), 32'h0);
        check("rst_dist_valid", 32'(dist_valid), 32'h0);
        check("rst_dist_timeout", 32'(dist_timeout), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_disabled", 32'(busy), 32'h0);

        // Sonar 0: trigger width and a 40-tick echo
        enable = 1'b1;
        wait_trig(seen);
        check("first_trig", 32'(seen), 32'h1);
        w = 0;
        while (trig[0] && w < 100) begin @(negedge clk); w++; end
        check("trig_width_clk", 32'(w), 32'd6);
        expect_pub(3'd0, 14'd40, 1'b0, 1);
        fire_echo(0, 30, 40);

        // Sonar 1: no echo, then sonar 2 must be next
        wait_trig(seen);
        check("trig_s1", 32'(seen), 32'h2);
        expect_pub(3'd1, 14'h3FFF, 1'b1, 0);
        wait_trig(seen);
        check("trig_after_timeout", 32'(seen), 32'h4);
        expect_pub(3'd2, 14'd5, 1'b0, 1);
        fire_echo(2, 20, 5);

        wait_trig(seen);
        check("trig_s3", 32'(seen), 32'h8);
        expect_pub(3'd3, 14'd10, 1'b0, 1);
        fire_echo(3, 20, 10);

        wait_trig(seen);
        check("trig_wrap_s0", 32'(seen), 32'h1);
        expect_pub(3'd0, 14'd15, 1'b0, 1);
        fire_echo(0, 20, 15);

        wait_trig(seen);
        check("trig_s1_again", 32'(seen), 32'h2);
        expect_pub(3'd1, 14'd20, 1'b0, 1);
        fire_echo(1, 20, 20);

        // Sonar 2: enable dropped mid-measurement
        wait_trig(seen);
        check("trig_s2_again", 32'(seen), 32'h4);
        expect_pub(3'd2, 14'd30, 1'b0, 1);
        wait_trig_fall();
        repeat (20) @(negedge clk);
        echo[2] = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        repeat (50) @(negedge clk);
        echo[2] = 1'b0;
        wait_idle(500);
        check("stop_busy", 32'(busy), 32'h0);
        check("stop_trig", 32'(trig), 32'h0);
        check("stop_sb_drained", 32'(sb.size()), 32'h0);

        // Resume at sonar 3, echo held past saturation
        enable = 1'b1;
        wait_trig(seen);
        check("resume_trig", 32'(seen), 32'h8);
        expect_pub(3'd3, 14'h3FFF, 1'b1, 0);
        wait_trig_fall();
        repeat (10) @(negedge clk);
        echo[3] = 1'b1;
        repeat (4) @(negedge clk);
        enable = 1'b0;
        repeat (17000 * TD) @(negedge clk);
        echo[3] = 1'b0;
        wait_idle(500);
        check("sat_busy", 32'(busy), 32'h0);
        check("sat_sb_drained", 32'(sb.size()), 32'h0);

        // Asynchronous reset while sonar 1 triggers
        enable = 1'b1;
        wait_trig(seen);
        check("wrap_after_sat", 32'(seen), 32'h1);
        expect_pub(3'd0, 14'h3FFF, 1'b1, 0);
        wait_trig(seen);
        check("trig_before_reset", 32'(seen), 32'h2);
        repeat (2) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("async_rst_trig", 32'(trig), 32'h0);
        check("async_rst_busy", 32'(busy), 32'h0);
        check("async_rst_data", 32'(dist_data), 32'h0);
        check("async_rst_timeout", 32'(dist_timeout), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        wait_trig(seen);
        check("trig_after_reset", 32'(seen), 32'h1);
        enable = 1'b0;
        expect_pub(3'd0, 14'h3FFF, 1'b1, 0);
        wait_idle(500);
        repeat (5) @(negedge clk);
        check("final_sb_drained", 32'(sb.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
